inert_sensor_rdr: RTL

//  Producer side of the inertial_integrator input interface (vld/ptch_rt/AZ).

---
 rtl/inert_sensor_rdr_if.sv | 15 +
 rtl/inert_sensor_rdr.sv | 78 +++++++
 2 files changed

// File: rtl/inert_sensor_rdr_if.sv
// inert_sensor_rdr_if: bundles the SPI-monarch handshake, IMU interrupt and sample outputs
//  master: reader side (drives wrt/cmd/vld/ptch_rt/AZ, takes INT/done/rd_data)
//  slave : SPI monarch + IMU + integrator side (the mirror image)
interface inert_sensor_rdr_if;
  logic        INT;
  logic        done;
  logic [15:0] rd_data;
  logic        wrt;
  logic [15:0] cmd;
  logic        vld;
  logic [15:0] ptch_rt;
  logic [15:0] AZ;
  modport master (input INT, done, rd_data, output wrt, cmd, vld, ptch_rt, AZ);
  modport slave (output INT, done, rd_data, input wrt, cmd, vld, ptch_rt, AZ);
endinterface

// File: rtl/inert_sensor_rdr.sv
// inert_sensor_rdr: powers up the IMU, then reads pitch rate and Z accel per data-ready interrupt
//  clk, rst : system clock, asynchronous active-high reset
//  bus      : INT/done/rd_data in; wrt/cmd SPI request out; vld/ptch_rt/AZ sample out
module inert_sensor_rdr #(
  parameter int INIT_W = 16
) (
  input logic                 clk,
  input logic                 rst,
  inert_sensor_rdr_if.master  bus
);
  typedef enum logic [2:0] {WAIT, CFG, IDLE, RD, VLD} state_t;
  state_t            state;
  logic [INIT_W-1:0] timer;
  logic [1:0]        idx;
  logic              busy, pend, rise;
  logic [2:0]        int_s;
  logic [7:0]        b [4];
  logic [15:0]       cfg_cmd, rd_cmd;
  assign rise = int_s[1] & ~int_s[2];
  assign cfg_cmd = idx == 2'd0 ? 16'h0D02 : idx == 2'd1 ? 16'h1053 : idx == 2'd2 ? 16'h1150 : 16'h1460;
  assign rd_cmd  = idx == 2'd0 ? 16'hA200 : idx == 2'd1 ? 16'hA300 : idx == 2'd2 ? 16'hAC00 : 16'hAD00;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT;
      timer       <= '0;
      idx         <= '0;
      busy        <= 1'b0;
      pend        <= 1'b0;
      int_s       <= '0;
      b           <= '{default: 8'h00};
      bus.wrt     <= 1'b0;
      bus.cmd     <= 16'h0000;
      bus.vld     <= 1'b0;
      bus.ptch_rt <= 16'h0000;
      bus.AZ      <= 16'h0000;
    end else begin
      int_s   <= {int_s[1:0], bus.INT};
      pend    <= pend | rise;
      bus.wrt <= 1'b0;
      bus.vld <= 1'b0;
      case (state)
        WAIT: begin
          if (&timer) begin
            state <= CFG;
            idx   <= '0;
          end else timer <= timer + 1'b1;
        end
        CFG, RD: begin
          // busy marks an outstanding transaction; done outside one is ignored
          if (!busy) begin
            bus.wrt <= 1'b1;
            bus.cmd <= state == CFG ? cfg_cmd : rd_cmd;
            busy    <= 1'b1;
          end else if (bus.done) begin
            busy <= 1'b0;
            idx  <= idx + 1'b1;
            if (state == RD) b[idx] <= bus.rd_data[7:0];
            if (idx == 2'd3) state <= state == CFG ? IDLE : VLD;
          end
        end
        IDLE: begin
          // an edge landing on the same clock as the clear re-arms pend
          if (pend) begin
            state <= RD;
            idx   <= '0;
            pend  <= rise;
          end
        end
        default: begin
          bus.ptch_rt <= {b[1], b[0]};
          bus.AZ      <= {b[3], b[2]};
          bus.vld     <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end
endmodule
